instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the pipelined core, directly upstream of the instruction memory. Owns the program counter, drives the memory's byte read address, captures the returned word into the IF/ID pipeline register, and handles hazard stalls, branch/jump redirects, and end-of-program halt. Downstream decode consumes the IF/ID outputs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_LAST_ADDR, 72, highest valid instruction byte address; fetch halts beyond it.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit hold: freeze PC and IF/ID.
- redirect  in  1  branch taken or jal/jalr resolved: load redirect_target.
- redirect_target  in  32  new PC on redirect.
- imem_addr  out  32  byte address to instruction memory (= PC, combinational).
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_pc_plus4  out  32  if_id_pc + 4 (link value).
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- halted  out  1  PC has passed IMEM_LAST_ADDR.
- fetch_count  out  32  number of valid instructions latched into IF/ID.
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registered state: pc, IF/ID bundle, halted, fetch_count, misalign_err.
- Per-cycle priority: reset > redirect > stall > halted > normal fetch.
- Normal: pc <= pc+4; IF/ID <= {imem_data, pc, pc+4, valid=1}; fetch_count += 1.
- Stall (no redirect): pc, IF/ID, fetch_count hold.
- Redirect: pc <= redirect_target; IF/ID <= {NOP_INSTR, pc, pc+4, valid=0} (squash wrong-path word); halted <= 0. Redirect overrides a concurrent stall.
- Halt: when pc > IMEM_LAST_ADDR and no redirect, halted <= 1; pc holds; IF/ID loaded with NOP_INSTR, valid=0 each cycle (unless stalled); fetch_count holds. Only redirect or reset leaves halt.
- Arithmetic: pc+4 modulo 2^32, wraps silently; fetch_count saturates at 32'hFFFF_FFFF.

## Timing
- Reset (async assert, sync-safe deassert): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, halted=0, fetch_count=0, misalign_err=0.
- imem_addr changes only after rising edge; instruction at PC P appears on if_id_instr one cycle after imem_addr=P.
- First valid IF/ID after reset release: first rising edge, instruction at RESET_PC.
- Redirect penalty: exactly one bubble; target's instruction valid in IF/ID two edges after redirect sampled.
- Stall asserted N cycles: IF/ID unchanged for N edges, no instruction lost or duplicated.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

## Configuration
- Macro IFU_MISALIGN_CHECK_EN.
- Defined: on redirect with redirect_target[1:0] != 0, pc <= {redirect_target[31:2],2'b00} and misalign_err set, sticky until reset.
- Undefined: redirect_target loaded verbatim; misalign_err tied 0 (port still present).

## Test plan
- Reset release, no stall/redirect, memory returns distinct words at 0,4,8 -> IF/ID shows words at pc 0,4,8 on edges 1,2,3; fetch_count=3.
- Stall for 2 cycles while pc=12 -> imem_addr stays 12, IF/ID keeps pc=8 word for 2 edges, then pc=12 word; no skip.
- Redirect to 24 while pc=20 -> next edge pc=24, if_id_valid=0, if_id_instr=32'h00000013; following edge valid word from 24.
- Redirect and stall same cycle to 36 -> redirect wins: pc=36, bubble in IF/ID.
- Run past 72 -> pc holds at 76, halted=1, if_id_valid=0, fetch_count frozen at 19; redirect to 0 clears halted.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x1E -> pc=0x1C, misalign_err=1 held until rst_n low; without macro pc=0x1E, misalign_err=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction memory port, and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is the surrounding core/memory side.
interface instr_fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic        misalign_err;

    modport master (
        input  stall, redirect, redirect_target, imem_data,
        output imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
               halted, fetch_count, misalign_err
    );

    modport slave (
        output stall, redirect, redirect_target, imem_data,
        input  imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
               halted, fetch_count, misalign_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register, stall/redirect/halt handling.
// Optional macro IFU_MISALIGN_CHECK_EN aligns redirect targets and raises a sticky misalign_err.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] IMEM_LAST_ADDR = 32'd72,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        past_end;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic        misalign_err;

    assign pc_plus4 = pc + 32'd4;
    assign past_end = (pc > IMEM_LAST_ADDR);

`ifdef IFU_MISALIGN_CHECK_EN
    assign redirect_pc = {bus.redirect_target[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (bus.redirect && (bus.redirect_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign redirect_pc  = bus.redirect_target;
    assign misalign_err = 1'b0;
`endif

    // Priority: redirect > stall > halted > normal fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
            fetch_count    <= 32'd0;
        end else if (bus.redirect) begin
            // Squash the wrong-path word currently on imem_data.
            pc             <= redirect_pc;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else if (bus.stall) begin
            pc <= pc;
        end else if (past_end) begin
            halted         <= 1'b1;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b0;
        end else begin
            pc             <= pc_plus4;
            if_id_instr    <= bus.imem_data;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            if (fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    assign bus.imem_addr      = pc;
    assign bus.if_id_instr    = if_id_instr;
    assign bus.if_id_pc       = if_id_pc;
    assign bus.if_id_pc_plus4 = if_id_pc_plus4;
    assign bus.if_id_valid    = if_id_valid;
    assign bus.halted         = halted;
    assign bus.fetch_count    = fetch_count;
    assign bus.misalign_err   = misalign_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch, stall, redirect, halt, wrap, misalign, async reset.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;
    logic [31:0] ma;
    logic        me;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign bus.imem_data = word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic exp_st(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] ipc, input logic [31:0] ipc4, input logic valid,
                          input logic halt, input logic [31:0] cnt);
        chk({tag, ".addr"},  bus.imem_addr, addr);
        chk({tag, ".instr"}, bus.if_id_instr, instr);
        chk({tag, ".pc"},    bus.if_id_pc, ipc);
        chk({tag, ".pc4"},   bus.if_id_pc_plus4, ipc4);
        chk({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
        chk({tag, ".halt"},  {31'd0, bus.halted}, {31'd0, halt});
        chk({tag, ".count"}, bus.fetch_count, cnt);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
`ifdef IFU_MISALIGN_CHECK_EN
        ma = 32'h1C;
        me = 1'b1;
`else
        ma = 32'h1E;
        me = 1'b0;
`endif
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        exp_st("rst", 32'd0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rst.mis", {31'd0, bus.misalign_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(); exp_st("f0", 32'd4,  word(32'd0), 32'd0, 32'd4,  1'b1, 1'b0, 32'd1);
        step(); exp_st("f4", 32'd8,  word(32'd4), 32'd4, 32'd8,  1'b1, 1'b0, 32'd2);
        step(); exp_st("f8", 32'd12, word(32'd8), 32'd8, 32'd12, 1'b1, 1'b0, 32'd3);

        bus.stall = 1'b1;
        step(); exp_st("stall1", 32'd12, word(32'd8), 32'd8, 32'd12, 1'b1, 1'b0, 32'd3);
        step(); exp_st("stall2", 32'd12, word(32'd8), 32'd8, 32'd12, 1'b1, 1'b0, 32'd3);
        bus.stall = 1'b0;
        step(); exp_st("f12", 32'd16, word(32'd12), 32'd12, 32'd16, 1'b1, 1'b0, 32'd4);
        step(); exp_st("f16", 32'd20, word(32'd16), 32'd16, 32'd20, 1'b1, 1'b0, 32'd5);

        bus.redirect = 1'b1; bus.redirect_target = 32'd24;
        step(); exp_st("redir24", 32'd24, NOP, 32'd20, 32'd24, 1'b0, 1'b0, 32'd5);
        bus.redirect = 1'b0;
        step(); exp_st("f24", 32'd28, word(32'd24), 32'd24, 32'd28, 1'b1, 1'b0, 32'd6);
        step(); exp_st("f28", 32'd32, word(32'd28), 32'd28, 32'd32, 1'b1, 1'b0, 32'd7);

        bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'd36;
        step(); exp_st("redir_stall", 32'd36, NOP, 32'd32, 32'd36, 1'b0, 1'b0, 32'd7);
        bus.stall = 1'b0; bus.redirect = 1'b0;

        // Addresses 36..72 inclusive: ten instructions.
        for (int i = 0; i < 10; i++) step();
        exp_st("f72", 32'd76, word(32'd72), 32'd72, 32'd76, 1'b1, 1'b0, 32'd17);
        step(); exp_st("halt1", 32'd76, NOP, 32'd76, 32'd80, 1'b0, 1'b1, 32'd17);
        step(); exp_st("halt2", 32'd76, NOP, 32'd76, 32'd80, 1'b0, 1'b1, 32'd17);

        bus.redirect = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
        step(); exp_st("redir_hi", 32'hFFFF_FFFC, NOP, 32'd76, 32'd80, 1'b0, 1'b0, 32'd17);
        bus.redirect = 1'b0;
        step(); exp_st("wrap_halt", 32'hFFFF_FFFC, NOP, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b1, 32'd17);

        bus.redirect = 1'b1; bus.redirect_target = 32'd0;
        step(); exp_st("redir0", 32'd0, NOP, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0, 32'd17);
        bus.redirect = 1'b0;
        step(); exp_st("f0b", 32'd4, word(32'd0), 32'd0, 32'd4, 1'b1, 1'b0, 32'd18);

        bus.redirect = 1'b1; bus.redirect_target = 32'h1E;
        step(); exp_st("mis", ma, NOP, 32'd4, 32'd8, 1'b0, 1'b0, 32'd18);
        chk("mis.flag", {31'd0, bus.misalign_err}, {31'd0, me});
        bus.redirect = 1'b0;
        step(); exp_st("fmis", ma + 32'd4, word(ma), ma, ma + 32'd4, 1'b1, 1'b0, 32'd19);
        chk("mis.sticky", {31'd0, bus.misalign_err}, {31'd0, me});

        #2 rst_n = 1'b0;
        #1;
        exp_st("arst", 32'd0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("arst.mis", {31'd0, bus.misalign_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
